jet_readout_arbiter: RTL and testbench

JET_READOUT_ARBITER -- requirements
Module: jet_readout_arbiter

---
 rtl/jet_pkg.sv | 33 +++
 rtl/jet_readout_arbiter_if.sv | 30 +++
 rtl/jet_out_fifo.sv | 61 ++++++
 rtl/jet_readout_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_jet_readout_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jet_pkg.sv
// Shared constants and types for the jet readout path.
// Jet word layout: {nt[4:0], nx[3:0], phi[4:0], et[8:0]}.
package jet_pkg;

    localparam int JET_W  = 23;
    localparam int NJET_W = 5;
    localparam int NPHI   = 27;

    localparam int ET_LSB  = 0;
    localparam int ET_W    = 9;
    localparam int PHI_LSB = 9;
    localparam int PHI_W   = 5;
    localparam int NX_LSB  = 14;
    localparam int NX_W    = 4;
    localparam int NT_LSB  = 18;
    localparam int NT_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } arb_state_e;

    function automatic int slice_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A slice never holds more than one jet per phi bin.
    function automatic logic [NJET_W-1:0] clamp_njet(input logic [NJET_W-1:0] n);
        return (n > NJET_W'(NPHI)) ? NJET_W'(NPHI) : n;
    endfunction

endpackage

// File: rtl/jet_readout_arbiter_if.sv
// Output jet stream: valid/ready handshake carrying jet word,
// source slice and end-of-event marker.
interface jet_readout_arbiter_if #(
    parameter int SW = 2
);
    import jet_pkg::*;

    logic [JET_W-1:0] out_jet;
    logic [SW-1:0]    out_slice;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        output out_jet,
        output out_slice,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_jet,
        input  out_slice,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/jet_out_fifo.sv
// Register-based show-ahead FIFO; the head entry is always
// visible on o_rdata and a pop and push may share a cycle.
module jet_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 26,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/jet_readout_arbiter.sv
// Round-robin readout of per-slice jet memories onto one link,
// with credit-based issue so the output FIFO can never overflow.
module jet_readout_arbiter
    import jet_pkg::*;
#(
    parameter int NSLICE     = 4,
    parameter int READ_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     evt_done,
    input  logic [NSLICE*NJET_W-1:0] njet_in,
    input  logic [NSLICE*JET_W-1:0]  jet_in,
    output logic [NJET_W-1:0]        jet_addr,
    output logic                     busy,
    output logic                     evt_end,
    output logic                     evt_overrun,
    jet_readout_arbiter_if.master    out_if
);

    localparam int SW = slice_w(NSLICE);
    localparam int FW = JET_W + SW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic [NJET_W-1:0] r_njet [NSLICE];
    logic [SW-1:0]     r_cur;
    logic [SW-1:0]     r_rr_ptr;
    logic [NJET_W-1:0] r_addr;
    logic              r_overrun;

    logic          r_tag_v [READ_LAT];
    logic [SW-1:0] r_tag_s [READ_LAT];
    logic          r_tag_l [READ_LAT];

    logic [NSLICE-1:0] w_mask;
    int                w_base;
    logic              w_found;
    logic [SW-1:0]     w_next;
    int                w_inflight;
    logic              w_credit;
    logic              w_issue;
    logic              w_slice_last;
    logic              w_evt_last;

    logic [JET_W-1:0] w_rd_jet;
    logic [FW-1:0]    w_wdata;
    logic [FW-1:0]    w_rdata;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [CW-1:0]    w_count;

    // In IDLE the search covers the incoming counts from rr_ptr;
    // while issuing it covers the slices not yet read out.
    always_comb begin
        w_mask = '0;
        w_base = 0;
        if (r_state == ST_IDLE) begin
            w_base = int'(r_rr_ptr);
            for (int s = 0; s < NSLICE; s++) begin
                w_mask[s] = (njet_in[s*NJET_W +: NJET_W] != '0);
            end
        end else begin
            w_base = (int'(r_cur) + 1) % NSLICE;
            for (int s = 0; s < NSLICE; s++) begin
                w_mask[s] = (r_njet[s] != '0) && (SW'(s) != r_cur);
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (!w_found && w_mask[(w_base + k) % NSLICE]) begin
                w_found = 1'b1;
                w_next  = SW'((w_base + k) % NSLICE);
            end
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < READ_LAT; k++) begin
            w_inflight = w_inflight + (r_tag_v[k] ? 1 : 0);
        end
    end

    assign w_credit     = (int'(w_count) + w_inflight) < FIFO_DEPTH;
    assign w_slice_last = (r_addr == r_njet[r_cur] - 1'b1);
    assign w_evt_last   = w_slice_last && !w_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (evt_done) begin
                    w_state_nxt = w_found ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (w_issue && w_evt_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_inflight == 0 && w_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = (r_state == ST_ISSUE) && w_credit;
        jet_addr = w_issue ? r_addr : '0;
        busy     = (r_state != ST_IDLE);
        evt_end  = (r_state == ST_DRAIN) && (w_inflight == 0) && w_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_cur     <= '0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
            for (int s = 0; s < NSLICE; s++) begin
                r_njet[s] <= '0;
            end
        end else begin
            if (evt_done && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == ST_IDLE) && evt_done) begin
                for (int s = 0; s < NSLICE; s++) begin
                    r_njet[s] <= clamp_njet(njet_in[s*NJET_W +: NJET_W]);
                end
                r_cur    <= w_next;
                r_addr   <= '0;
                r_rr_ptr <= (int'(r_rr_ptr) == NSLICE - 1) ? '0 : r_rr_ptr + 1'b1;
            end else if (w_issue) begin
                if (w_slice_last) begin
                    r_njet[r_cur] <= '0;
                    r_cur         <= w_next;
                    r_addr        <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Tag pipeline mirrors the slice read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                r_tag_v[k] <= 1'b0;
                r_tag_s[k] <= '0;
                r_tag_l[k] <= 1'b0;
            end
        end else begin
            r_tag_v[0] <= w_issue;
            r_tag_s[0] <= r_cur;
            r_tag_l[0] <= w_issue && w_evt_last;
            for (int k = 1; k < READ_LAT; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag_s[k] <= r_tag_s[k-1];
                r_tag_l[k] <= r_tag_l[k-1];
            end
        end
    end

    assign w_rd_jet = jet_in[int'(r_tag_s[READ_LAT-1])*JET_W +: JET_W];
    assign w_push   = r_tag_v[READ_LAT-1];
    assign w_wdata  = {r_tag_l[READ_LAT-1], r_tag_s[READ_LAT-1], w_rd_jet};
    assign w_pop    = out_if.out_ready && !w_empty;

    jet_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_if.out_valid = !w_empty;
    assign out_if.out_jet   = w_empty ? '0 : w_rdata[JET_W-1:0];
    assign out_if.out_slice = w_empty ? '0 : w_rdata[JET_W +: SW];
    assign out_if.out_last  = !w_empty && w_rdata[FW-1];
    assign evt_overrun      = r_overrun;

endmodule

// File: tb/tb_jet_readout_arbiter.sv
// Directed bench with a queue-based readout model for the
// jet readout arbiter.
module tb_jet_readout_arbiter;
    import jet_pkg::*;

    localparam int NS  = 4;
    localparam int RL  = 3;
    localparam int FD  = 8;
    localparam int SW  = 2;
    localparam int FW  = JET_W + SW + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 evt_done;
    logic [NS*NJET_W-1:0] njet_in;
    logic [NS*JET_W-1:0]  jet_in;
    logic [NJET_W-1:0]    jet_addr;
    logic                 busy;
    logic                 evt_end;
    logic                 evt_overrun;

    jet_readout_arbiter_if #(.SW(SW)) link ();

    jet_readout_arbiter #(
        .NSLICE     (NS),
        .READ_LAT   (RL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .evt_done    (evt_done),
        .njet_in     (njet_in),
        .jet_in      (jet_in),
        .jet_addr    (jet_addr),
        .busy        (busy),
        .evt_end     (evt_end),
        .evt_overrun (evt_overrun),
        .out_if      (link)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int evt_id   = 0;
    int m_rr     = 0;
    int words_seen;
    logic [7:0] seen_sl;
    logic [FW-1:0] exp_q [$];
    logic [NJET_W-1:0] hist [RL];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slice memory contents: every field depends on slice, address and event.
    function automatic logic [JET_W-1:0] mem_word(input int s, input int a, input int e);
        logic [JET_W-1:0] w;
        w = '0;
        w[ET_LSB  +: ET_W]  = ET_W'(a * 7 + s * 31 + e * 13 + 1);
        w[PHI_LSB +: PHI_W] = PHI_W'((a + 3 * s) % NPHI);
        w[NX_LSB  +: NX_W]  = NX_W'(s);
        w[NT_LSB  +: NT_W]  = NT_W'(a);
        return w;
    endfunction

    always @(posedge clk) begin
        hist[0] <= jet_addr;
        for (int k = 1; k < RL; k++) begin
            hist[k] <= hist[k-1];
        end
    end

    always_comb begin
        jet_in = '0;
        for (int s = 0; s < NS; s++) begin
            jet_in[s*JET_W +: JET_W] = mem_word(s, int'(hist[RL-1]), evt_id);
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (link.out_valid && link.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(link.out_jet), 64'h0dead);
                end else begin
                    chk("word", {link.out_last, link.out_slice, link.out_jet},
                        exp_q.pop_front());
                end
                words_seen++;
                seen_sl = {seen_sl[5:0], link.out_slice};
            end
            if (evt_end) begin
                chk("evt_end_drained", exp_q.size(), 0);
            end
        end
    end

    task automatic launch(input int n0, input int n1, input int n2, input int n3);
        int n [NS];
        int nn;
        int s;
        logic [FW-1:0] e;
        n = '{n0, n1, n2, n3};
        @(negedge clk);
        evt_id++;
        words_seen = 0;
        seen_sl    = '0;
        for (int k = 0; k < NS; k++) begin
            njet_in[k*NJET_W +: NJET_W] = NJET_W'(n[k]);
        end
        for (int k = 0; k < NS; k++) begin
            s  = (m_rr + k) % NS;
            nn = (n[s] > NPHI) ? NPHI : n[s];
            for (int a = 0; a < nn; a++) begin
                e = {1'b0, SW'(s), mem_word(s, a, evt_id)};
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q[exp_q.size()-1];
            e[FW-1] = 1'b1;
            exp_q[exp_q.size()-1] = e;
        end
        m_rr = (m_rr + 1) % NS;
        evt_done = 1'b1;
        @(negedge clk);
        evt_done = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (evt_end) break;
        end
        chk(nm, 64'(i < 300), 1);
    endtask

    initial begin
        int exp_addr [6];
        exp_addr = '{0, 1, 2, 0, 1, 0};
        reset = 1'b1;
        evt_done = 1'b0;
        njet_in = '0;
        link.out_ready = 1'b1;
        words_seen = 0;
        seen_sl = '0;
        repeat (3) @(negedge clk);
        chk("rst_jet_addr", jet_addr, 0);
        chk("rst_out_valid", link.out_valid, 0);
        chk("rst_out_last", link.out_last, 0);
        chk("rst_out_slice", link.out_slice, 0);
        chk("rst_out_jet", link.out_jet, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt_end", evt_end, 0);
        chk("rst_overrun", evt_overrun, 0);
        reset = 1'b0;

        launch(3, 0, 2, 1);
        chk("model_size_e1", exp_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("e1_addr%0d", i), jet_addr, exp_addr[i]);
        end
        @(negedge clk);
        chk("e1_addr_idle", jet_addr, 0);
        chk("e1_busy_drain", busy, 1);
        wait_end("e1_end");
        chk("e1_words", words_seen, 6);

        launch(1, 1, 1, 1);
        wait_end("e2_end");
        chk("e2_words", words_seen, 4);
        chk("e2_order", seen_sl, 8'h6C);

        launch(0, 0, 0, 0);
        chk("e3_evt_end", evt_end, 1);
        chk("e3_busy", busy, 1);
        @(negedge clk);
        chk("e3_busy_off", busy, 0);
        chk("e3_evt_end_off", evt_end, 0);
        chk("e3_words", words_seen, 0);

        link.out_ready = 1'b0;
        launch(27, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("e4_stall_addr%0d", k), jet_addr, (k < FD) ? k : 0);
        end
        chk("e4_busy", busy, 1);
        chk("e4_words_held", words_seen, 0);
        link.out_ready = 1'b1;
        wait_end("e4_end");
        chk("e4_words", words_seen, 27);

        launch(0, 31, 0, 4);
        begin
            int i;
            for (i = 0; i < 400; i++) begin
                @(negedge clk);
                if (evt_end) break;
                link.out_ready = 1'($urandom_range(0, 1));
            end
            chk("e5_end", 64'(i < 400), 1);
        end
        link.out_ready = 1'b1;
        chk("e5_words", words_seen, 31);

        launch(2, 2, 2, 2);
        @(negedge clk);
        @(negedge clk);
        njet_in = {4{5'd9}};
        evt_done = 1'b1;
        @(negedge clk);
        evt_done = 1'b0;
        chk("e6_overrun", evt_overrun, 1);
        wait_end("e6_end");
        chk("e6_words", words_seen, 8);
        @(negedge clk);
        chk("e6_overrun_held", evt_overrun, 1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        m_rr = 0;
        chk("e6_overrun_clr", evt_overrun, 0);

        launch(5, 5, 5, 5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        m_rr = 0;
        chk("e7_valid", link.out_valid, 0);
        chk("e7_busy", busy, 0);
        chk("e7_addr", jet_addr, 0);
        launch(1, 2, 0, 3);
        wait_end("e8_end");
        chk("e8_words", words_seen, 6);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
